// File: rtl/corelet_ctrl.sv
// Tile sequencer for one corelet: fetches SRAM vectors, drives L0/IFIFO/MAC/OFIFO/SFU strobes, drains OFIFO to PSUM.
// Optional drain watchdog: define CORELET_CTRL_TIMEOUT_EN to enable the 64-cycle DRAIN timeout and the err flag.
module corelet_ctrl #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_bw = 11,
  parameter int cnt_bw  = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               cfg_os,
  input  logic [cnt_bw-1:0]  cfg_nvec,
  input  logic [addr_bw-1:0] cfg_xbase,
  input  logic [addr_bw-1:0] cfg_wbase,
  input  logic [addr_bw-1:0] cfg_pbase,
  output logic               xmem_cen,
  output logic [addr_bw-1:0] xmem_addr,
  output logic               wmem_cen,
  output logic [addr_bw-1:0] wmem_addr,
  output logic               pmem_wen,
  output logic [addr_bw-1:0] pmem_addr,
  output logic               ld_mode,
  output logic               l0_wr,
  output logic               l0_rd,
  output logic               ififo_wr,
  output logic               ififo_rd,
  output logic               kflush,
  output logic               execute,
  output logic               ofifo_rd,
  output logic               ofifo_wr_ext,
  output logic               sfu_acc,
  output logic               sfu_relu,
  output logic               os_or_ws,
  input  logic               ofifo_valid,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int KW = $clog2(row + col);
  localparam int CW = (KW > cnt_bw) ? KW + 1 : cnt_bw + 1;
  localparam logic [CW-1:0] ROW_LAST = CW'(row - 1);
  localparam logic [CW-1:0] ROW_N    = CW'(row);
  localparam logic [CW-1:0] KF_LAST  = CW'(row + col - 1);

  typedef enum logic [2:0] {IDLE, WLOAD, KLOAD, EXEC, FLUSH, DRAIN, FIN} state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [CW-1:0]      rd_cnt;
  logic [cnt_bw-1:0]  nvec;
  logic [addr_bw-1:0] xbase_q;
  logic [addr_bw-1:0] p_ptr;
  logic [CW-1:0]      nvec_w;
  logic [CW-1:0]      drain_tgt;

  assign nvec_w    = CW'(nvec);
  assign drain_tgt = os_or_ws ? ROW_N : nvec_w;

`ifdef CORELET_CTRL_TIMEOUT_EN
  logic [5:0] tmo;
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      rd_cnt       <= '0;
      nvec         <= '0;
      xbase_q      <= '0;
      p_ptr        <= '0;
      xmem_cen     <= 1'b0;
      xmem_addr    <= '0;
      wmem_cen     <= 1'b0;
      wmem_addr    <= '0;
      pmem_wen     <= 1'b0;
      pmem_addr    <= '0;
      ld_mode      <= 1'b0;
      l0_wr        <= 1'b0;
      l0_rd        <= 1'b0;
      ififo_wr     <= 1'b0;
      ififo_rd     <= 1'b0;
      kflush       <= 1'b0;
      execute      <= 1'b0;
      ofifo_rd     <= 1'b0;
      ofifo_wr_ext <= 1'b0;
      sfu_acc      <= 1'b0;
      sfu_relu     <= 1'b0;
      os_or_ws     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
`ifdef CORELET_CTRL_TIMEOUT_EN
      tmo          <= '0;
      err          <= 1'b0;
`endif
    end else begin
      // Read-data strobes trail their SRAM enables regardless of state, so a
      // read issued on the last cycle of a phase still lands downstream.
      done         <= 1'b0;
      ofifo_wr_ext <= 1'b0;
      l0_wr        <= xmem_cen;
      ififo_wr     <= wmem_cen;
      pmem_wen     <= ofifo_rd;
      if (ofifo_rd) begin
        pmem_addr <= p_ptr;
        p_ptr     <= p_ptr + 1'b1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            busy     <= 1'b1;
            os_or_ws <= cfg_os;
            sfu_relu <= cfg_os;
            sfu_acc  <= 1'b0;
            nvec     <= (cfg_nvec == '0) ? cnt_bw'(1) : cfg_nvec;
            xbase_q  <= cfg_xbase;
            p_ptr    <= cfg_pbase;
            cnt      <= '0;
            xmem_cen <= 1'b1;
`ifdef CORELET_CTRL_TIMEOUT_EN
            err      <= 1'b0;
`endif
            if (cfg_os) begin
              state     <= EXEC;
              xmem_addr <= cfg_xbase;
              wmem_cen  <= 1'b1;
              wmem_addr <= cfg_wbase;
            end else begin
              state     <= WLOAD;
              xmem_addr <= cfg_wbase;
              ld_mode   <= 1'b1;
            end
          end
        end

        WLOAD: begin
          if (cnt == ROW_LAST) begin
            state    <= KLOAD;
            cnt      <= '0;
            xmem_cen <= 1'b0;
            kflush   <= 1'b1;
          end else begin
            cnt       <= cnt + 1'b1;
            xmem_addr <= xmem_addr + 1'b1;
          end
        end

        KLOAD: begin
          l0_rd <= (cnt < ROW_N);
          if (cnt == KF_LAST) begin
            state     <= EXEC;
            cnt       <= '0;
            kflush    <= 1'b0;
            ld_mode   <= 1'b0;
            xmem_cen  <= 1'b1;
            xmem_addr <= xbase_q;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // execute/l0_rd/ififo_rd share l0_wr's timing: each vector is consumed
        // the cycle it lands, so all N fit inside the N+1 EXEC cycles.
        EXEC: begin
          execute  <= xmem_cen;
          l0_rd    <= xmem_cen;
          ififo_rd <= os_or_ws & xmem_cen;
          if (cnt == nvec_w) begin
            cnt <= '0;
            if (os_or_ws) begin
              state        <= FLUSH;
              kflush       <= 1'b1;
              ofifo_wr_ext <= 1'b1;
            end else begin
              state    <= DRAIN;
              sfu_acc  <= 1'b1;
              ofifo_rd <= ofifo_valid;
              rd_cnt   <= CW'(ofifo_valid);
`ifdef CORELET_CTRL_TIMEOUT_EN
              tmo      <= '0;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt + 1'b1 < nvec_w) begin
              xmem_addr <= xmem_addr + 1'b1;
              if (os_or_ws) wmem_addr <= wmem_addr + 1'b1;
            end else begin
              xmem_cen <= 1'b0;
              wmem_cen <= 1'b0;
            end
          end
        end

        FLUSH: begin
          if (cnt == KF_LAST) begin
            state    <= DRAIN;
            cnt      <= '0;
            kflush   <= 1'b0;
            ofifo_rd <= ofifo_valid;
            rd_cnt   <= CW'(ofifo_valid);
`ifdef CORELET_CTRL_TIMEOUT_EN
            tmo      <= '0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Leave once the final read is on the bus; its PSUM write lands in FIN.
        DRAIN: begin
          if (ofifo_rd && rd_cnt == drain_tgt) begin
            state    <= FIN;
            ofifo_rd <= 1'b0;
            sfu_acc  <= 1'b0;
          end else begin
            ofifo_rd <= ofifo_valid && (rd_cnt < drain_tgt);
            if (ofifo_valid && (rd_cnt < drain_tgt)) rd_cnt <= rd_cnt + 1'b1;
`ifdef CORELET_CTRL_TIMEOUT_EN
            if (ofifo_valid) begin
              tmo <= '0;
            end else if (tmo == 6'd63) begin
              state    <= FIN;
              err      <= 1'b1;
              ofifo_rd <= 1'b0;
              sfu_acc  <= 1'b0;
            end else begin
              tmo <= tmo + 1'b1;
            end
`endif
          end
        end

        FIN: begin
          state    <= IDLE;
          done     <= 1'b1;
          busy     <= 1'b0;
          os_or_ws <= 1'b0;
          sfu_relu <= 1'b0;
          sfu_acc  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
